// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and constants for the data-port arbiter
package mem_port_arbiter_pkg;
  localparam int ARB_NREQ = 2;
  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef struct packed {
    logic we;
    logic [3:0] be;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
    logic [2:0] storecntrl;
  } mem_cmd_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the memory-controller data port
interface mem_port_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic req0_valid;
  logic req0_we;
  logic [3:0] req0_be;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic [2:0] req0_storecntrl;
  logic req0_ack;
  logic req0_err;
  logic [DW-1:0] req0_rdata;
  logic req1_valid;
  logic req1_we;
  logic [3:0] req1_be;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic [2:0] req1_storecntrl;
  logic req1_ack;
  logic req1_err;
  logic [DW-1:0] req1_rdata;
  logic [3:0] mem_en;
  logic mem_wea;
  logic mem_rea;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [2:0] storecntrl;
  logic [DW-1:0] mem_dout;
  logic mem_hold;
  logic owner;
  modport master (
    output req0_valid, req0_we, req0_be, req0_addr, req0_wdata, req0_storecntrl,
    input  req0_ack, req0_err, req0_rdata,
    output req1_valid, req1_we, req1_be, req1_addr, req1_wdata, req1_storecntrl,
    input  req1_ack, req1_err, req1_rdata,
    input  mem_en, mem_wea, mem_rea, mem_addr, mem_din, storecntrl, owner,
    output mem_dout, mem_hold
  );
  modport slave (
    input  req0_valid, req0_we, req0_be, req0_addr, req0_wdata, req0_storecntrl,
    output req0_ack, req0_err, req0_rdata,
    input  req1_valid, req1_we, req1_be, req1_addr, req1_wdata, req1_storecntrl,
    output req1_ack, req1_err, req1_rdata,
    output mem_en, mem_wea, mem_rea, mem_addr, mem_din, storecntrl, owner,
    input  mem_dout, mem_hold
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [ARB_NREQ-1:0] valid,
  input  logic last_grant,
  output logic grant_idx,
  output logic any
);
  // on a tie the requester that did not win last time goes next
  always_comb begin
    grant_idx = &valid ? ~last_grant : valid[1];
    any = |valid;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the memory data port between two requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int HOLD_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_TIMEOUT);
  arb_state_t state, nxt;
  mem_cmd_t cmd;
  logic [CW-1:0] hold_cnt;
  logic abort;
  logic last_grant;
  logic owner_q;
  logic pick;
  logic pick_any;
  logic hold_expire;
  rr_pick2 u_pick (
    .valid({bus.req1_valid, bus.req0_valid}),
    .last_grant(last_grant),
    .grant_idx(pick),
    .any(pick_any)
  );
  assign hold_expire = bus.mem_hold && hold_cnt == HOLD_LAST;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: grant from IDLE, leave ISSUE on acceptance or hold timeout, RESP lasts one cycle
  always_comb
    nxt = state == IDLE ? (pick_any ? ISSUE : IDLE)
        : state == ISSUE ? ((!bus.mem_hold || hold_expire) ? RESP : ISSUE)
        : IDLE;
  // command latch, grant history, hold counter and abort flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd <= '0;
      owner_q <= 1'b0;
      last_grant <= 1'b1;
      hold_cnt <= '0;
      abort <= 1'b0;
    end else if (state == IDLE && pick_any) begin
      cmd <= pick ? '{we: bus.req1_we, be: bus.req1_be, addr: ARB_AW'(bus.req1_addr),
                      wdata: ARB_DW'(bus.req1_wdata), storecntrl: bus.req1_storecntrl}
                  : '{we: bus.req0_we, be: bus.req0_be, addr: ARB_AW'(bus.req0_addr),
                      wdata: ARB_DW'(bus.req0_wdata), storecntrl: bus.req0_storecntrl};
      owner_q <= pick;
      last_grant <= pick;
    end else if (state == ISSUE && bus.mem_hold) begin
      hold_cnt <= hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + CW'(1);
      abort <= hold_expire;
    end else if (state == RESP) begin
      hold_cnt <= '0;
      abort <= 1'b0;
    end
  // outputs decoded from registered state; only the owner sees ack/err/rdata
  always_comb begin
    bus.mem_en = state == ISSUE ? cmd.be : 4'h0;
    bus.mem_wea = state == ISSUE && cmd.we;
    bus.mem_rea = state == ISSUE && !cmd.we;
    bus.mem_addr = cmd.addr[AW-1:0];
    bus.mem_din = cmd.wdata[DW-1:0];
    bus.storecntrl = cmd.storecntrl;
    bus.owner = owner_q;
    bus.req0_ack = state == RESP && !owner_q;
    bus.req1_ack = state == RESP && owner_q;
    bus.req0_err = bus.req0_ack && abort;
    bus.req1_err = bus.req1_ack && abort;
    bus.req0_rdata = bus.req0_ack && !abort ? bus.mem_dout : '0;
    bus.req1_rdata = bus.req1_ack && !abort ? bus.mem_dout : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, latency, stalls, timeout and reset
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0, last, a0, a1;
  logic [31:0] b2b_a [3];
  logic [31:0] b2b_d [3];
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_t ();
  mem_port_arbiter #(.AW(32), .DW(32), .HOLD_TIMEOUT(255)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  mem_port_arbiter #(.AW(32), .DW(32), .HOLD_TIMEOUT(4)) dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));
  assign bus_t.req0_valid = bus.req0_valid;
  assign bus_t.req0_we = bus.req0_we;
  assign bus_t.req0_be = bus.req0_be;
  assign bus_t.req0_addr = bus.req0_addr;
  assign bus_t.req0_wdata = bus.req0_wdata;
  assign bus_t.req0_storecntrl = bus.req0_storecntrl;
  assign bus_t.req1_valid = bus.req1_valid;
  assign bus_t.req1_we = bus.req1_we;
  assign bus_t.req1_be = bus.req1_be;
  assign bus_t.req1_addr = bus.req1_addr;
  assign bus_t.req1_wdata = bus.req1_wdata;
  assign bus_t.req1_storecntrl = bus.req1_storecntrl;
  assign bus_t.mem_hold = bus.mem_hold;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h100 ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction
  // memory returns the word at whatever address was on the bus last cycle
  always @(posedge clk) begin
    bus.mem_dout <= memf(bus.mem_addr);
    bus_t.mem_dout <= memf(bus_t.mem_addr);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_be = 0; bus.req0_addr = 0;
    bus.req0_wdata = 0; bus.req0_storecntrl = 0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_be = 0; bus.req1_addr = 0;
    bus.req1_wdata = 0; bus.req1_storecntrl = 0;
    bus.mem_hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask
  initial begin
    b2b_a[0] = 32'h100; b2b_a[1] = 32'h200; b2b_a[2] = 32'h300;
    b2b_d[0] = 32'hDEAD_BEEF; b2b_d[1] = 32'h0200_FDFF; b2b_d[2] = 32'h0300_FCFF;
    do_reset;
    chk("rst_owner", bus.owner, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_wea", bus.mem_wea, 0);
    chk("rst_rea", bus.mem_rea, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_din", bus.mem_din, 0);
    chk("rst_ack0", bus.req0_ack, 0);
    chk("rst_ack1", bus.req1_ack, 0);
    chk("rst_err0", bus.req0_err, 0);
    chk("rst_rdata0", bus.req0_rdata, 0);
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_be = 4'hF;
    bus.req0_addr = 32'h100; bus.req0_storecntrl = 3'b010;
    tick;
    chk("rd_issue_rea", bus.mem_rea, 1);
    chk("rd_issue_wea", bus.mem_wea, 0);
    chk("rd_issue_addr", bus.mem_addr, 32'h100);
    chk("rd_issue_en", bus.mem_en, 4'hF);
    chk("rd_storecntrl", bus.storecntrl, 3'b010);
    chk("rd_issue_ack0", bus.req0_ack, 0);
    tick;
    chk("rd_rea_drop", bus.mem_rea, 0);
    chk("rd_ack0", bus.req0_ack, 1);
    chk("rd_rdata0", bus.req0_rdata, 32'hDEAD_BEEF);
    chk("rd_ack1", bus.req1_ack, 0);
    chk("rd_err0", bus.req0_err, 0);
    bus.req0_valid = 0;
    tick;
    chk("rd_idle_ack0", bus.req0_ack, 0);
    do_reset;
    bus.req0_valid = 1; bus.req0_addr = 32'h10; bus.req0_be = 4'hF;
    bus.req1_valid = 1; bus.req1_addr = 32'h20; bus.req1_be = 4'hF;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rr_owner", bus.owner, i % 2);
      chk("rr_addr", bus.mem_addr, (i % 2) ? 32'h20 : 32'h10);
      tick;
      a0 += int'(bus.req0_ack);
      a1 += int'(bus.req1_ack);
      chk("rr_ack_owner", (i % 2) ? bus.req1_ack : bus.req0_ack, 1);
      chk("rr_ack_other", (i % 2) ? bus.req0_ack : bus.req1_ack, 0);
      tick;
    end
    chk("rr_ack0_cnt", a0, 2);
    chk("rr_ack1_cnt", a1, 2);
    do_reset;
    bus.req1_valid = 1; bus.req1_we = 1; bus.req1_be = 4'hF; bus.req1_addr = 32'h2000;
    bus.req1_wdata = 32'h1234_5678; bus.req1_storecntrl = 3'b001;
    bus.mem_hold = 1;
    t0 = cyc;
    tick;
    for (int k = 0; k < 6; k++) begin
      chk("hs_wea", bus.mem_wea, 1);
      chk("hs_addr", bus.mem_addr, 32'h2000);
      chk("hs_din", bus.mem_din, 32'h1234_5678);
      chk("hs_en", bus.mem_en, 4'hF);
      chk("hs_ack1", bus.req1_ack, 0);
      bus.mem_hold = (k < 5);
      tick;
    end
    chk("hs_resp_ack1", bus.req1_ack, 1);
    chk("hs_resp_err1", bus.req1_err, 0);
    chk("hs_resp_wea", bus.mem_wea, 0);
    chk("hs_latency", cyc - t0, 7);
    bus.req1_valid = 0;
    tick;
    do_reset;
    bus.req1_valid = 1; bus.req1_we = 0; bus.req1_be = 4'hF; bus.req1_addr = 32'h40;
    bus.mem_hold = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk("to_rea", bus_t.mem_rea, 1);
      chk("to_ack1", bus_t.req1_ack, 0);
      tick;
    end
    chk("to_rea_drop", bus_t.mem_rea, 0);
    chk("to_abort_ack1", bus_t.req1_ack, 1);
    chk("to_abort_err1", bus_t.req1_err, 1);
    chk("to_abort_rdata1", bus_t.req1_rdata, 0);
    chk("to_abort_ack0", bus_t.req0_ack, 0);
    bus.req1_valid = 0; bus.mem_hold = 0;
    tick;
    chk("to_idle_ack1", bus_t.req1_ack, 0);
    chk("to_idle_err1", bus_t.req1_err, 0);
    chk("to_idle_rea", bus_t.mem_rea, 0);
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 32'h44;
    tick;
    chk("to_regrant_rea", bus_t.mem_rea, 1);
    chk("to_regrant_owner", bus_t.owner, 0);
    tick;
    chk("to_regrant_ack0", bus_t.req0_ack, 1);
    chk("to_regrant_err0", bus_t.req0_err, 0);
    do_reset;
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_be = 4'hF; bus.req0_addr = 32'h100;
    tick;
    chk("ar_issue_rea", bus.mem_rea, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rea", bus.mem_rea, 0);
    chk("ar_en", bus.mem_en, 0);
    chk("ar_addr", bus.mem_addr, 0);
    chk("ar_ack0", bus.req0_ack, 0);
    bus.req1_valid = 1; bus.req1_addr = 32'h200; bus.req1_be = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("ar_tie_owner", bus.owner, 0);
    chk("ar_tie_addr", bus.mem_addr, 32'h100);
    chk("ar_no_ack0", bus.req0_ack, 0);
    do_reset;
    bus.req0_valid = 1; bus.req0_we = 0; bus.req0_be = 4'hF;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      bus.req0_addr = b2b_a[i];
      tick;
      chk("b2b_addr", bus.mem_addr, b2b_a[i]);
      tick;
      chk("b2b_ack0", bus.req0_ack, 1);
      chk("b2b_rdata0", bus.req0_rdata, b2b_d[i]);
      if (i > 0) chk("b2b_gap", cyc - last, 3);
      last = cyc;
      tick;
      chk("b2b_idle_ack0", bus.req0_ack, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
